// File: rtl/qc_timing_pkg.sv
// Shared types, default widths and the wrap-safe lateness test for the timed issuer.
package qc_timing_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, ISSUE} tc_state_t;

  localparam int TC_NUM_CH = 4;
  localparam int TC_T_W    = 20;
  localparam int TC_OP_W   = 7;
  localparam int TC_ANG_W  = 11;
  localparam int TC_ADDR_W = 11;

  // The MSB of (t_inst - (t_now + 1)) mod 2^w is set when the word is already due or past.
  function automatic logic is_late(input logic [31:0] t_inst, input logic [31:0] t_now,
                                   input int w);
    logic [31:0] d;
    d = t_inst - t_now - 32'd1;
    return ((d >> (w - 1)) & 32'd1) != 32'd0;
  endfunction

endpackage

// File: rtl/time_channel.sv
// One issuer channel: pops a timed word, waits for its timestamp, writes it to memory.
module time_channel
  import qc_timing_pkg::*;
#(
  parameter int T_W       = TC_T_W,
  parameter int OP_W      = TC_OP_W,
  parameter int ANG_W     = TC_ANG_W,
  parameter int ADDR_W    = TC_ADDR_W,
  parameter int LATE_MODE = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [T_W-1:0]                t_now_i,
  input  logic                          fifo_empty_i,
  input  logic [T_W+OP_W+ANG_W-1:0]     fifo_data_i,
  output logic                          fifo_rd_en_o,
  output logic [OP_W+ANG_W-1:0]         data_o,
  output logic                          wr_en_o,
  output logic [ADDR_W-1:0]             addr_o,
  input  logic                          late_clr_i,
  output logic                          late_o,
  output logic                          busy_o
);

  localparam int DW = OP_W + ANG_W;
  localparam int WW = T_W + DW;

  tc_state_t         state_q;
  logic [WW-1:0]     word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DW-1:0]     data_q;
  logic              wr_q;
  logic              late_q;

  logic [T_W-1:0]    t_inst;
  logic [T_W-1:0]    delta_d;
  logic              late_d;

  assign t_inst  = word_q[WW-1 -: T_W];
  assign delta_d = t_inst - t_now_i - {{(T_W-1){1'b0}}, 1'b1};
  assign late_d  = is_late(32'(t_inst), 32'(t_now_i), T_W);

  // Gating with reset keeps a write from escaping in the cycle the channel is being reset.
  assign fifo_rd_en_o = (state_q == IDLE) && !fifo_empty_i && !rst_i;
  assign wr_en_o      = wr_q && !rst_i;
  assign data_o       = rst_i ? '0 : data_q;
  assign addr_o       = addr_q;
  assign late_o       = late_q;
  assign busy_o       = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      data_q <= '0;
      if (late_clr_i) late_q <= 1'b0;
      case (state_q)
        IDLE: if (!fifo_empty_i) state_q <= LOAD;
        LOAD: begin
          word_q  <= fifo_data_i;
          state_q <= WAIT;
        end
        WAIT: begin
          // Late detection takes priority; a set overrides a same-cycle clear.
          if (late_d) begin
            late_q <= 1'b1;
            if (LATE_MODE != 0) begin
              state_q <= ISSUE;
              wr_q    <= 1'b1;
              data_q  <= word_q[DW-1:0];
            end else begin
              state_q <= IDLE;
            end
          end else if (delta_d == '0) begin
            state_q <= ISSUE;
            wr_q    <= 1'b1;
            data_q  <= word_q[DW-1:0];
          end
        end
        ISSUE: begin
          addr_q  <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/time_controller_mc.sv
// Multi-channel timed instruction issuer: NUM_CH independent channels sliced off shared buses.
module time_controller_mc
  import qc_timing_pkg::*;
#(
  parameter int NUM_CH    = TC_NUM_CH,
  parameter int T_W       = TC_T_W,
  parameter int OP_W      = TC_OP_W,
  parameter int ANG_W     = TC_ANG_W,
  parameter int ADDR_W    = TC_ADDR_W,
  parameter int LATE_MODE = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [T_W-1:0]                        t_cnt,
  output logic [NUM_CH-1:0]                     fifo_rd_en,
  input  logic [NUM_CH*(T_W+OP_W+ANG_W)-1:0]    fifo_data,
  input  logic [NUM_CH-1:0]                     fifo_empty,
  output logic [NUM_CH*(OP_W+ANG_W)-1:0]        o_data,
  output logic [NUM_CH-1:0]                     o_data_wr_en,
  output logic [NUM_CH*ADDR_W-1:0]              o_data_mem_addr,
  input  logic [NUM_CH-1:0]                     late_clr,
  output logic [NUM_CH-1:0]                     late_flag,
  output logic [NUM_CH-1:0]                     busy
);

  localparam int DW = OP_W + ANG_W;
  localparam int WW = T_W + DW;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    time_channel #(
      .T_W      (T_W),
      .OP_W     (OP_W),
      .ANG_W    (ANG_W),
      .ADDR_W   (ADDR_W),
      .LATE_MODE(LATE_MODE)
    ) u_ch (
      .clk_i       (clk),
      .rst_i       (reset),
      .t_now_i     (t_cnt),
      .fifo_empty_i(fifo_empty[c]),
      .fifo_data_i (fifo_data[c*WW +: WW]),
      .fifo_rd_en_o(fifo_rd_en[c]),
      .data_o      (o_data[c*DW +: DW]),
      .wr_en_o     (o_data_wr_en[c]),
      .addr_o      (o_data_mem_addr[c*ADDR_W +: ADDR_W]),
      .late_clr_i  (late_clr[c]),
      .late_o      (late_flag[c]),
      .busy_o      (busy[c])
    );
  end

endmodule

// File: tb/tb_time_controller_mc.sv
// Bench for time_controller_mc: drop-mode and issue-mode instances fed from modelled FIFOs.
module tb_time_controller_mc;

  localparam int NC = 4;
  localparam int TW = 20;
  localparam int DW = 18;
  localparam int WW = 38;
  localparam int AW = 11;

  logic              clk = 1'b0;
  logic              reset;
  logic [TW-1:0]     t_cnt;
  logic [NC-1:0]     late_clr;
  logic [NC*WW-1:0]  fdata     [2];
  logic [NC-1:0]     fempty    [2];
  logic [NC-1:0]     rd_en     [2];
  logic [NC-1:0]     wr_en     [2];
  logic [NC-1:0]     late_flag [2];
  logic [NC-1:0]     busy      [2];
  logic [NC*DW-1:0]  odata     [2];
  logic [NC*AW-1:0]  oaddr     [2];

  always #5 clk = ~clk;

  time_controller_mc #(.LATE_MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .t_cnt(t_cnt),
    .fifo_rd_en(rd_en[0]), .fifo_data(fdata[0]), .fifo_empty(fempty[0]),
    .o_data(odata[0]), .o_data_wr_en(wr_en[0]), .o_data_mem_addr(oaddr[0]),
    .late_clr(late_clr), .late_flag(late_flag[0]), .busy(busy[0])
  );

  time_controller_mc #(.LATE_MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .t_cnt(t_cnt),
    .fifo_rd_en(rd_en[1]), .fifo_data(fdata[1]), .fifo_empty(fempty[1]),
    .o_data(odata[1]), .o_data_wr_en(wr_en[1]), .o_data_mem_addr(oaddr[1]),
    .late_clr(late_clr), .late_flag(late_flag[1]), .busy(busy[1])
  );

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } ev_t;

  // Index k = instance*4 + channel.
  logic [WW-1:0] fq  [8][$];
  ev_t           evq [8][$];
  bit            late_exp [8];
  int            exp_addr [8];
  logic          rd_s     [8];
  logic [TW-1:0] base_g;
  int            cyc;
  int            last_g;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    t_cnt = base_g + TW'(cyc);
    for (int k = 0; k < 8; k++) begin
      if (rd_s[k] && fq[k].size() > 0)
        fdata[k/4][(k%4)*WW +: WW] = fq[k].pop_front();
      fempty[k/4][k%4] = (fq[k].size() == 0);
    end
  endtask

  task automatic cycle_check();
    logic          ew;
    logic [DW-1:0] ed;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rd_s[k] = rd_en[k/4][k%4];
      ew = 1'b0;
      ed = '0;
      if (evq[k].size() > 0 && evq[k][0].cyc == cyc) begin
        ew = 1'b1;
        ed = evq[k][0].data;
      end
      check_val($sformatf("m%0d_ch%0d_wr_data_addr", k/4, k%4),
                {34'd0, wr_en[k/4][k%4], odata[k/4][(k%4)*DW +: DW], oaddr[k/4][(k%4)*AW +: AW]},
                {34'd0, ew, ed, AW'(exp_addr[k])});
      if (ew) begin
        void'(evq[k].pop_front());
        exp_addr[k] = (exp_addr[k] + 1) % 2048;
      end
    end
  endtask

  // Timing of one channel from its queued words: idle at f, evaluated in WAIT at f+2,
  // written in the cycle whose t_cnt equals the timestamp (or right away when late in mode 1).
  task automatic model_ch(input int k, input int m);
    int            f;
    int            w;
    int            i;
    logic [TW-1:0] ti;
    logic [TW-1:0] d;
    ev_t           e;
    f = 0;
    for (int j = 0; j < fq[k].size(); j++) begin
      ti = fq[k][j][WW-1 -: TW];
      w  = f + 2;
      d  = ti - (base_g + TW'(w)) - 20'd1;
      if (d[TW-1]) begin
        late_exp[k] = 1'b1;
        i = (m == 0) ? -1 : w + 1;
        if (m == 0) f = w + 1;
        if (w + 1 > last_g) last_g = w + 1;
      end else begin
        i = w + 1 + int'(d);
      end
      if (i >= 0) begin
        e.cyc  = i;
        e.data = fq[k][j][DW-1:0];
        evq[k].push_back(e);
        f = i + 1;
        if (i > last_g) last_g = i;
      end
    end
  endtask

  task automatic begin_trial();
    reset    = 1'b1;
    late_clr = '0;
    for (int k = 0; k < 8; k++) begin
      fq[k].delete();
      evq[k].delete();
      late_exp[k] = 1'b0;
      exp_addr[k] = 0;
      rd_s[k]     = 1'b0;
    end
    step();
  endtask

  task automatic push_word(input int ch, input logic [TW-1:0] t, input logic [DW-1:0] d);
    fq[ch].push_back({t, d});
    fq[ch+4].push_back({t, d});
  endtask

  task automatic start_run(input logic [TW-1:0] base, input int ncyc, input bit do_end);
    int n;
    for (int k = 0; k < 8; k++) fempty[k/4][k%4] = (fq[k].size() == 0);
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      check_val($sformatf("m%0d_rst_rd_en", m), 64'(rd_en[m]), 64'd0);
      check_val($sformatf("m%0d_rst_wr_en", m), 64'(wr_en[m]), 64'd0);
      check_val($sformatf("m%0d_rst_data", m), 64'(odata[m]), 64'd0);
      check_val($sformatf("m%0d_rst_addr", m), 64'(oaddr[m]), 64'd0);
      check_val($sformatf("m%0d_rst_late", m), 64'(late_flag[m]), 64'd0);
      check_val($sformatf("m%0d_rst_busy", m), 64'(busy[m]), 64'd0);
    end
    step();
    reset  = 1'b0;
    cyc    = 0;
    base_g = base;
    t_cnt  = base;
    last_g = 0;
    for (int k = 0; k < 8; k++) model_ch(k, k / 4);
    n = (ncyc > 0) ? ncyc : last_g + 4;
    for (int i = 0; i <= n; i++) begin
      cycle_check();
      step();
    end
    if (do_end) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        check_val($sformatf("m%0d_ch%0d_pending_writes", k/4, k%4), 64'(evq[k].size()), 64'd0);
        check_val($sformatf("m%0d_ch%0d_fifo_drained", k/4, k%4), 64'(fq[k].size()), 64'd0);
      end
      for (int m = 0; m < 2; m++) begin
        check_val($sformatf("m%0d_idle_busy", m), 64'(busy[m]), 64'd0);
        check_val($sformatf("m%0d_late_flag", m), 64'(late_flag[m]),
                  64'({late_exp[m*4+3], late_exp[m*4+2], late_exp[m*4+1], late_exp[m*4]}));
      end
      step();
      late_clr = '1;
      step();
      late_clr = '0;
      @(negedge clk);
      for (int m = 0; m < 2; m++)
        check_val($sformatf("m%0d_late_clr", m), 64'(late_flag[m]), 64'd0);
    end
  endtask

  initial begin
    logic [TW-1:0] b;
    logic [TW-1:0] ti;
    reset    = 1'b1;
    late_clr = '0;
    t_cnt    = '0;
    base_g   = '0;
    cyc      = 0;
    for (int m = 0; m < 2; m++) begin
      fdata[m]  = '0;
      fempty[m] = '1;
    end

    // Single issue at t=100.
    begin_trial();
    push_word(0, 20'd100, {7'd5, 11'h2A});
    start_run(20'd0, 0, 1'b1);

    // Parallel channels.
    begin_trial();
    push_word(0, 20'd50, {7'd1, 11'h111});
    push_word(1, 20'd50, {7'd2, 11'h222});
    push_word(2, 20'd60, {7'd3, 11'h333});
    start_run(20'd0, 0, 1'b1);

    // Late word: dropped by instance 0, issued at once by instance 1.
    begin_trial();
    push_word(0, 20'd150, {7'd9, 11'h7FF});
    start_run(20'd200, 0, 1'b1);

    // Time wrap: a small timestamp just past the wrap is in the future.
    begin_trial();
    push_word(3, 20'h00003, {7'h7F, 11'h055});
    start_run(20'hFFFFC, 0, 1'b1);

    // Address wrap: 2049 back-to-back words at the minimum spacing.
    begin_trial();
    for (int j = 0; j < 2049; j++)
      push_word(0, TW'(4*j + 3), DW'($urandom));
    start_run(20'd0, 0, 1'b1);

    // Reset while waiting, then a fresh word must land at address 0.
    begin_trial();
    push_word(0, 20'd500, {7'd4, 11'h0AA});
    start_run(20'd0, 300, 1'b0);
    begin_trial();
    push_word(0, 20'd40, {7'd6, 11'h0BB});
    start_run(20'd0, 0, 1'b1);

    // Randomised words, some near the counter wrap, some late.
    for (int t = 0; t < 10; t++) begin
      begin_trial();
      b = (t % 3 == 0) ? 20'hFFFFF - TW'($urandom_range(0, 60)) : TW'($urandom);
      for (int c = 0; c < NC; c++) begin
        for (int j = 0; j < int'($urandom_range(0, 5)); j++) begin
          ti = b + TW'($urandom_range(0, 250)) - 20'd40;
          push_word(c, ti, DW'($urandom));
        end
      end
      start_run(b, 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
